// File: rtl/fir64_mac_i16.sv
// fir64_mac_i16: 64-tap int16 FIR, one multiply-accumulate per cycle over a circular delay line.
// Define FIR64_SYMFOLD_EN to fold symmetric coefficients (32 taps with a pre-adder).
module fir64_mac_i16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [5:0]  cmem_a,
  input  logic [15:0] cmem_q,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);
`ifdef FIR64_SYMFOLD_EN
  localparam logic [6:0] NTAP = 7'd32;
  localparam int PW = 33;
`else
  localparam logic [6:0] NTAP = 7'd64;
  localparam int PW = 32;
`endif
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t r_state, w_next;
  logic [15:0] r_mem [64];
  logic [5:0] r_wptr;
  logic [6:0] r_tap;
  logic signed [37:0] r_acc;
  logic [15:0] r_out;
  logic w_last;
  logic [5:0] w_ia;
  logic [15:0] w_xa;
  logic signed [PW-1:0] w_prod;
  logic signed [37:0] w_prod_ext;
  logic signed [22:0] w_shift;
  logic w_ovf;
  logic [15:0] w_sat;
  // newest sample sits at wptr-1, so x[n-k] is at wptr-1-k = wptr + ~k
  assign w_ia = r_wptr + ~r_tap[5:0];
  assign w_xa = r_mem[w_ia];
`ifdef FIR64_SYMFOLD_EN
  logic [5:0] w_ib;
  logic [15:0] w_xb;
  logic signed [16:0] w_pre;
  assign w_ib = r_wptr + r_tap[5:0];
  assign w_xb = r_mem[w_ib];
  assign w_pre = $signed({w_xa[15], w_xa}) + $signed({w_xb[15], w_xb});
  assign w_prod = w_pre * $signed(cmem_q);
`else
  assign w_prod = $signed(w_xa) * $signed(cmem_q);
`endif
  assign w_prod_ext = {{(38-PW){w_prod[PW-1]}}, w_prod};
  assign w_shift = 23'((r_acc + 38'sd16384) >>> 15);
  assign w_ovf = |w_shift[22:15] & ~&w_shift[22:15];
  assign w_sat = w_ovf ? (w_shift[22] ? 16'h8000 : 16'h7FFF) : w_shift[15:0];
  assign w_last = r_tap == NTAP;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = MAC;
    if (r_state == MAC && w_last) w_next = OUT;
    if (r_state == OUT && out_ready) w_next = IDLE;
    in_ready = r_state == IDLE;
    out_valid = r_state == OUT;
    cmem_a = (r_state == MAC && !w_last) ? r_tap[5:0] : 6'd0;
    out_data = r_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_acc <= '0;
      r_tap <= '0;
      r_out <= '0;
      for (int i = 0; i < 64; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_mem[r_wptr] <= in_data;
        r_wptr <= r_wptr + 6'd1;
        r_acc <= '0;
        r_tap <= '0;
      end
      if (r_state == MAC && !w_last) begin
        r_acc <= r_acc + w_prod_ext;
        r_tap <= r_tap + 7'd1;
      end
      if (r_state == MAC && w_last) r_out <= w_sat;
    end
  end
endmodule

// File: doc/fir64_mac_i16.md
FIR64_MAC_I16 -- requirements
Module: fir64_mac_i16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: input sample offered.
REQ-004 SHALL have port in_data, input, 16 bits: signed two's-complement Q1.15 sample.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-006 SHALL have port cmem_a, output, 6 bits: coefficient address into the 64-entry int16 coefficient ROM.
REQ-007 SHALL have port cmem_q, input, 16 bits: signed coefficient, combinational response to cmem_a in the same cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: filtered result available.
REQ-009 SHALL have port out_data, output, 16 bits: signed Q1.15 filtered sample.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes result.

Function
REQ-011 SHALL implement y[n] = sum over k=0..63 of c[k]*x[n-k], with c[k] = cmem_q at cmem_a=k.
REQ-012 SHALL keep a 64x16 circular delay line with a 6-bit write pointer that wraps 63->0.
REQ-013 SHALL use FSM states IDLE, MAC, OUT; in_ready = 1 only in IDLE.
REQ-014 IDLE: on in_valid & in_ready, write in_data at wptr, advance wptr, clear accumulator, go to MAC.
REQ-015 MAC: one tap per cycle; cmem_a = k for k = 0..63; accumulate signed product into a 38-bit accumulator; after tap 63, go to OUT.
REQ-016 SHALL drive cmem_a = 0 outside MAC.
REQ-017 Product: 16x16 signed -> 32 bits, sign-extended to 38 bits; accumulation SHALL never wrap.
REQ-018 Output: (acc + 2^14) arithmetically shifted right by 15, saturated to [0x8000, 0x7FFF], registered into out_data on entry to OUT.
REQ-019 out_valid SHALL rise on the 65th rising edge after the accepting edge, in the unfolded build.
REQ-020 OUT: hold out_valid=1 and a stable out_data until out_ready=1; on out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
REQ-021 No sample SHALL be accepted or lost while in MAC or OUT; the next sample can be accepted one cycle after the handshake at the earliest.
REQ-022 out_data SHALL retain its last value after the handshake.

Reset
REQ-023 When rst=1 at a rising edge, the next state SHALL be: IDLE, wptr=0, all delay-line entries 0, acc=0, tap counter 0, out_valid=0, out_data=0.
REQ-024 Reset asserted mid-MAC or mid-OUT SHALL abort the computation; no out_valid pulse is produced for the aborted sample.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro FIR64_SYMFOLD_EN, when defined, SHALL exploit coefficient symmetry c[k]=c[63-k]: MAC runs k=0..31, cmem_a=k, pre-adds x[n-k]+x[n-63+k] to 17 bits, uses a 17x16 product, and keeps a 38-bit accumulator.
REQ-027 With FIR64_SYMFOLD_EN defined, out_valid SHALL rise on the 33rd edge after acceptance, and results SHALL be bit-identical to the unfolded build for symmetric coefficient sets.
REQ-028 Without FIR64_SYMFOLD_EN, the block SHALL be exactly REQ-011..REQ-022: 64 taps, no pre-adder.

Verification
REQ-029 Impulse: after reset, feed 0x7FFF then 63 samples of 0x0000, with the team coefficient ROM attached -> output i equals c[i], e.g. output 0 = 0xFFFF, output 31 = 0x2500, output 63 = 0xFFFF.
REQ-030 Saturation: bench drives cmem_q=0x7FFF and in_data=0x7FFF for 64 samples -> last out_data=0x7FFF; the same with in_data=0x8000 -> 0x8000.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_data stays stable, in_ready=0 and in_valid is ignored; release -> exactly one handshake.
REQ-032 Latency: accept at edge t -> out_valid first high after edge t+65 (t+33 with FIR64_SYMFOLD_EN); cmem_a sequence 0..63 (0..31) on consecutive cycles.
REQ-033 Reset mid-MAC: assert rst at tap 20 -> next cycle IDLE, out_valid=0, and a following impulse reproduces REQ-029 exactly (delay line cleared).
REQ-034 Random: 1000 random samples with random in_valid/out_ready, compared against a golden model in both macro builds -> zero mismatches and wptr wraps at least 15 times.
